// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: ALU command codes, shift types, forwarding
// selects, NZCV bit positions and the multiplier FSM state encoding.
package arm_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] MUL_CMD = 4'b1010;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    // Selects 11 falls back to the register value, same as 00.
    function automatic logic [31:0] fwd_mux(input logic [1:0] sel,
                                            input logic [31:0] reg_v,
                                            input logic [31:0] mem_v,
                                            input logic [31:0] wb_v);
        case (sel)
            FWD_MEM: return mem_v;
            FWD_WB:  return wb_v;
            default: return reg_v;
        endcase
    endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE -> EXE -> EXE/MEM signal bundle; master is the pipeline around the
// stage, slave is exe_stage itself.
interface exe_stage_if;
    logic        imm, s, b, mem_r_en, mem_w_en, wb_en;
    logic [3:0]  exec_cmd;
    logic [3:0]  dest;
    logic [11:0] shift_operand;
    logic [23:0] signed_immed_24;
    logic [31:0] pc, val_rn, val_rm;
    logic [1:0]  fwd_sel_rn, fwd_sel_rm;
    logic [31:0] mem_fwd, wb_fwd;

    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out;
    logic [3:0]  dest_out;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status;
    logic        stall;

    modport master (
        output imm, s, b, mem_r_en, mem_w_en, wb_en, exec_cmd, dest,
               shift_operand, signed_immed_24, pc, val_rn, val_rm,
               fwd_sel_rn, fwd_sel_rm, mem_fwd, wb_fwd,
        input  alu_res, store_data, wb_en_out, mem_r_en_out, mem_w_en_out,
               dest_out, branch_taken, branch_addr, status, stall
    );

    modport slave (
        input  imm, s, b, mem_r_en, mem_w_en, wb_en, exec_cmd, dest,
               shift_operand, signed_immed_24, pc, val_rn, val_rm,
               fwd_sel_rn, fwd_sel_rm, mem_fwd, wb_fwd,
        output alu_res, store_data, wb_en_out, mem_r_en_out, mem_w_en_out,
               dest_out, branch_taken, branch_addr, status, stall
    );
endinterface

// File: rtl/exe_stage_val2_gen.sv
// Second ALU operand: load/store offset, rotated 8-bit immediate, or shifted Rm.
module val2_gen
    import arm_pkg::*;
(
    input  logic        imm_i,
    input  logic        ldst_i,
    input  logic [11:0] shift_operand_i,
    input  logic [31:0] rm_i,
    output logic [31:0] val2_o
);

    logic [63:0] imm_rot_s;
    logic [63:0] rm_rot_s;
    logic [4:0]  sh_amt_s;

    // Doubled operands turn rotate-right into a plain right shift.
    always_comb begin
        sh_amt_s  = shift_operand_i[11:7];
        imm_rot_s = {24'd0, shift_operand_i[7:0], 24'd0, shift_operand_i[7:0]}
                    >> {shift_operand_i[11:8], 1'b0};
        rm_rot_s  = {rm_i, rm_i} >> sh_amt_s;
        val2_o    = 32'd0;
        if (ldst_i) begin
            val2_o = {20'd0, shift_operand_i};
        end else if (imm_i) begin
            val2_o = imm_rot_s[31:0];
        end else begin
            case (shift_operand_i[6:5])
                SH_LSL:  val2_o = rm_i << sh_amt_s;
                SH_LSR:  val2_o = rm_i >> sh_amt_s;
                SH_ASR:  val2_o = $unsigned($signed(rm_i) >>> sh_amt_s);
                SH_ROR:  val2_o = rm_rot_s[31:0];
                default: val2_o = rm_i;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: forwarding, Val2, ALU, branch target, NZCV register and a
// 32-cycle shift-add multiplier that stalls upstream while it runs.
module exe_stage
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    exe_stage_if.slave  bus
);

    logic [31:0] op1_s, rm_f_s, val2_s, alu_res_s;
    logic [32:0] sum_s;
    logic        alu_c_s, alu_v_s, stall_s, is_mul_s;
    logic [3:0]  status_q, status_d;
    mul_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;

    assign op1_s    = fwd_mux(bus.fwd_sel_rn, bus.val_rn, bus.mem_fwd, bus.wb_fwd);
    assign rm_f_s   = fwd_mux(bus.fwd_sel_rm, bus.val_rm, bus.mem_fwd, bus.wb_fwd);
    assign is_mul_s = (bus.exec_cmd == MUL_CMD);

    val2_gen u_val2 (
        .imm_i           (bus.imm),
        .ldst_i          (bus.mem_r_en | bus.mem_w_en),
        .shift_operand_i (bus.shift_operand),
        .rm_i            (rm_f_s),
        .val2_o          (val2_s)
    );

    // ALU; logic and move commands pass the current C and V through.
    always_comb begin
        alu_res_s = 32'd0;
        sum_s     = 33'd0;
        alu_c_s   = status_q[C_IDX];
        alu_v_s   = status_q[V_IDX];
        case (bus.exec_cmd)
            CMD_MOV: alu_res_s = val2_s;
            CMD_MVN: alu_res_s = ~val2_s;
            CMD_ADD, CMD_ADC: begin
                sum_s = {1'b0, op1_s} + {1'b0, val2_s}
                      + {32'd0, (bus.exec_cmd == CMD_ADC) & status_q[C_IDX]};
                alu_res_s = sum_s[31:0];
                alu_c_s   = sum_s[32];
                alu_v_s   = (op1_s[31] == val2_s[31]) && (sum_s[31] != op1_s[31]);
            end
            CMD_SUB, CMD_SBC: begin
                sum_s = {1'b0, op1_s} - {1'b0, val2_s}
                      - {32'd0, (bus.exec_cmd == CMD_SBC) & ~status_q[C_IDX]};
                alu_res_s = sum_s[31:0];
                alu_c_s   = ~sum_s[32];
                alu_v_s   = (op1_s[31] != val2_s[31]) && (sum_s[31] != op1_s[31]);
            end
            CMD_AND: alu_res_s = op1_s & val2_s;
            CMD_ORR: alu_res_s = op1_s | val2_s;
            CMD_EOR: alu_res_s = op1_s ^ val2_s;
            default: alu_res_s = 32'd0;
        endcase
    end

    // Multiplier next state; operands are latched once because forwarded
    // values may move on while the pipeline is frozen.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        stall_s  = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (is_mul_s) begin
                    stall_s  = 1'b1;
                    mcand_d  = op1_s;
                    mplier_d = rm_f_s;
                    acc_d    = 32'd0;
                    cnt_d    = 5'd0;
                    state_d  = MUL_BUSY;
                end else begin
                    state_d  = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                stall_s = 1'b1;
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = MUL_DONE;
                end else begin
                    state_d = MUL_BUSY;
                end
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // Status next state: MUL touches only N and Z, and only in its DONE cycle.
    always_comb begin
        status_d = status_q;
        if (bus.s && !stall_s) begin
            if (state_q == MUL_DONE) begin
                status_d[N_IDX] = acc_q[31];
                status_d[Z_IDX] = (acc_q == 32'd0);
            end else begin
                status_d = {alu_res_s[31], (alu_res_s == 32'd0), alu_c_s, alu_v_s};
            end
        end else begin
            status_d = status_q;
        end
    end

    // State, multiplier datapath and NZCV registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            status_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            status_q <= status_d;
        end
    end

    // Output drive; stalls become bubbles downstream and reset forces all idle.
    always_comb begin
        bus.status      = status_q;
        bus.store_data  = rm_f_s;
        bus.branch_addr = bus.pc + {{6{bus.signed_immed_24[23]}}, bus.signed_immed_24, 2'b00};
        if (rst) begin
            bus.alu_res      = 32'd0;
            bus.wb_en_out    = 1'b0;
            bus.mem_r_en_out = 1'b0;
            bus.mem_w_en_out = 1'b0;
            bus.dest_out     = 4'd0;
            bus.branch_taken = 1'b0;
            bus.stall        = 1'b0;
        end else begin
            bus.alu_res      = (state_q == MUL_DONE) ? acc_q : alu_res_s;
            bus.wb_en_out    = bus.wb_en & ~stall_s;
            bus.mem_r_en_out = bus.mem_r_en & ~stall_s;
            bus.mem_w_en_out = bus.mem_w_en & ~stall_s;
            bus.dest_out     = bus.dest;
            bus.branch_taken = bus.b;
            bus.stall        = stall_s;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard-driven bench for exe_stage: expected alu_res values are queued
// when an instruction is presented and popped when the stage produces it.
module tb_exe_stage;
    import arm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    exe_stage_if bus ();

    exe_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.imm = 1'b0; bus.s = 1'b0; bus.b = 1'b0;
        bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0; bus.wb_en = 1'b0;
        bus.exec_cmd = 4'd0; bus.dest = 4'd0; bus.shift_operand = 12'd0;
        bus.signed_immed_24 = 24'd0; bus.pc = 32'd0;
        bus.val_rn = 32'd0; bus.val_rm = 32'd0;
        bus.fwd_sel_rn = FWD_REG; bus.fwd_sel_rm = FWD_REG;
        bus.mem_fwd = 32'd0; bus.wb_fwd = 32'd0;
    endtask

    task automatic check_alu(input string name);
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.alu_res !== exp_v) begin
            errors++;
            $display("FAIL %s: alu_res got %h expected %h", name, bus.alu_res, exp_v);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.exec_cmd = MUL_CMD; bus.wb_en = 1'b1; bus.b = 1'b1; bus.val_rn = 32'd5;
        exp_q.push_back(32'd0);
        #1;
        check_alu("reset_alu_res");
        checks++;
        if ({bus.stall, bus.branch_taken, bus.wb_en_out, bus.status} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got stall/br/wb/status %b expected 0000000",
                     {bus.stall, bus.branch_taken, bus.wb_en_out, bus.status});
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_add_flags();
        @(negedge clk);
        clear_inputs();
        bus.exec_cmd = CMD_ADD; bus.s = 1'b1; bus.imm = 1'b1; bus.wb_en = 1'b1;
        bus.val_rn = 32'h7FFF_FFFF; bus.shift_operand = 12'h001;
        exp_q.push_back(32'h8000_0000);
        #1;
        check_alu("add_overflow");
        checks++;
        if (bus.wb_en_out !== 1'b1) begin
            errors++;
            $display("FAIL add_wb_en_out: got %b expected 1", bus.wb_en_out);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.status !== 4'b1001) begin
            errors++;
            $display("FAIL add_status: got %b expected 1001", bus.status);
        end
        bus.exec_cmd = CMD_AND; bus.shift_operand = 12'h000;
        exp_q.push_back(32'd0);
        #1;
        check_alu("and_zero");
        @(posedge clk); #1;
        checks++;
        if (bus.status !== 4'b0101) begin
            errors++;
            $display("FAIL and_status_keeps_cv: got %b expected 0101", bus.status);
        end
    endtask

    task automatic test_val2();
        @(negedge clk);
        clear_inputs();
        bus.exec_cmd = CMD_MOV; bus.imm = 1'b1; bus.shift_operand = 12'h4FF;
        bus.val_rn = 32'h1234_5678;
        exp_q.push_back(32'hFF00_0000);
        #1; check_alu("imm_rotate");
        bus.imm = 1'b0; bus.val_rm = 32'h8000_0000;
        bus.shift_operand = {5'd4, SH_ASR, 1'b0, 4'd0};
        exp_q.push_back(32'hF800_0000);
        #1; check_alu("reg_asr4");
        bus.val_rm = 32'h1234_5678;
        bus.shift_operand = {5'd8, SH_ROR, 1'b0, 4'd0};
        exp_q.push_back(32'h7812_3456);
        #1; check_alu("reg_ror8");
        bus.exec_cmd = CMD_ADD; bus.mem_w_en = 1'b1; bus.val_rn = 32'h0000_1000;
        bus.shift_operand = 12'hFFF; bus.val_rm = 32'hCAFE_F00D;
        exp_q.push_back(32'h0000_1FFF);
        #1; check_alu("str_offset");
        checks++;
        if ({bus.mem_w_en_out, bus.store_data} !== {1'b1, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL str_data: got %b/%h expected 1/cafef00d",
                     bus.mem_w_en_out, bus.store_data);
        end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        clear_inputs();
        bus.exec_cmd = CMD_SUB; bus.imm = 1'b1; bus.shift_operand = 12'h002; bus.s = 1'b1;
        bus.val_rn = 32'd9; bus.mem_fwd = 32'd5; bus.wb_fwd = 32'd20;
        bus.fwd_sel_rn = FWD_MEM;
        exp_q.push_back(32'd3);
        #1; check_alu("fwd_mem_sub");
        @(posedge clk); #1;
        checks++;
        if (bus.status !== 4'b0010) begin
            errors++;
            $display("FAIL sub_status: got %b expected 0010", bus.status);
        end
        bus.s = 1'b0; bus.fwd_sel_rn = FWD_WB;
        exp_q.push_back(32'd18);
        #1; check_alu("fwd_wb_sub");
        bus.fwd_sel_rn = 2'b11; bus.exec_cmd = CMD_ADC;
        exp_q.push_back(32'd12);
        #1; check_alu("adc_carry_in");
        bus.exec_cmd = CMD_SBC;
        exp_q.push_back(32'd7);
        #1; check_alu("sbc_no_borrow");
    endtask

    task automatic test_branch();
        @(negedge clk);
        clear_inputs();
        bus.b = 1'b1; bus.pc = 32'h0000_0100; bus.signed_immed_24 = 24'hFFFFFE;
        #1;
        checks++;
        if ({bus.branch_taken, bus.branch_addr, bus.stall} !== {1'b1, 32'h0000_00F8, 1'b0}) begin
            errors++;
            $display("FAIL branch: got %b/%h/%b expected 1/000000f8/0",
                     bus.branch_taken, bus.branch_addr, bus.stall);
        end
    endtask

    // Runs a MUL already on the inputs through its stall window and DONE cycle.
    task automatic run_mul(input string name, input logic [3:0] exp_status_done,
                           input logic [3:0] exp_status_after);
        int n = 0;
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (bus.stall) begin
                n++;
                checks++;
                if ({bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out} !== 3'b000) begin
                    errors++;
                    $display("FAIL %s_bubble: got %b expected 000 at stall cycle %0d", name,
                             {bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out}, n);
                end
                if (n == 5) begin
                    bus.mem_fwd = 32'd100; bus.val_rm = 32'd99; bus.val_rn = 32'd77;
                end
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL %s_stall_cycles: got %0d expected 33", name, n);
        end
        check_alu({name, "_result"});
        checks++;
        if ({bus.wb_en_out, bus.dest_out, bus.status} !== {1'b1, 4'd3, exp_status_done}) begin
            errors++;
            $display("FAIL %s_done: got wb/dest/status %b/%0d/%b expected 1/3/%b", name,
                     bus.wb_en_out, bus.dest_out, bus.status, exp_status_done);
        end
        @(posedge clk); #1;
        clear_inputs();
        #1;
        checks++;
        if ({bus.stall, bus.status} !== {1'b0, exp_status_after}) begin
            errors++;
            $display("FAIL %s_after: got stall/status %b/%b expected 0/%b", name,
                     bus.stall, bus.status, exp_status_after);
        end
    endtask

    task automatic test_mul();
        @(negedge clk);
        clear_inputs();
        bus.exec_cmd = CMD_ADD; bus.s = 1'b1; bus.imm = 1'b1;
        bus.val_rn = 32'h7FFF_FFFF; bus.shift_operand = 12'h001;
        @(negedge clk);
        clear_inputs();
        bus.exec_cmd = MUL_CMD; bus.s = 1'b1; bus.wb_en = 1'b1; bus.dest = 4'd3;
        bus.fwd_sel_rn = FWD_MEM; bus.mem_fwd = 32'd7; bus.val_rm = 32'd6;
        exp_q.push_back(32'd42);
        #1;
        run_mul("mul", 4'b1001, 4'b0001);
    endtask

    task automatic test_reset_mid_mul();
        int n = 0;
        @(negedge clk);
        clear_inputs();
        bus.exec_cmd = MUL_CMD; bus.wb_en = 1'b1; bus.dest = 4'd3;
        bus.val_rn = 32'd3; bus.val_rm = 32'd5;
        #1;
        for (int i = 0; i < 40 && n < 11; i++) begin
            if (bus.stall) n++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        exp_q.push_back(32'd0);
        #1;
        check_alu("midmul_reset_alu");
        checks++;
        if ({bus.stall, bus.status, bus.wb_en_out} !== 6'd0) begin
            errors++;
            $display("FAIL midmul_reset: got stall/status/wb %b/%b/%b expected 0/0000/0",
                     bus.stall, bus.status, bus.wb_en_out);
        end
        @(negedge clk);
        bus.val_rn = 32'd3; bus.val_rm = 32'd5;
        rst = 1'b0;
        exp_q.push_back(32'd15);
        #1;
        run_mul("mul_after_reset", 4'b0000, 4'b0000);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_add_flags();
        test_val2();
        test_forwarding();
        test_branch();
        test_mul();
        test_reset_mid_mul();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM pipeline, fed by the ID/EXE pipeline register and feeding the EXE/MEM register. Holds the forwarding muxes, Val2 generator, ALU, branch-target adder, NZCV status register and an iterative 32-cycle shift-add multiplier. While a multiply runs, the block stalls the upstream stages and emits bubbles downstream.

## Interface
- MUL_CMD, 4'b1010, exec_cmd code for MUL; the other codes are MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imm, s, b, mem_r_en, mem_w_en, wb_en  in  1 each  decoded controls from ID/EXE
- exec_cmd  in  4  ALU command
- dest  in  4  destination register
- shift_operand  in  12  shifter operand / offset12
- signed_immed_24  in  24  branch offset (words)
- pc, val_rn, val_rm  in  32 each  PC+4, Rn and Rm values
- fwd_sel_rn, fwd_sel_rm  in  2 each  operand select: 00 register value, 01 mem_fwd, 10 wb_fwd, 11 register value
- mem_fwd, wb_fwd  in  32 each  forwarded results from MEM and WB
- alu_res  out  32  result / memory address
- store_data  out  32  forwarded Rm value for STR
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  gated controls
- dest_out  out  4  destination register
- branch_taken  out  1  equals b; flushes IF/ID and ID/EXE
- branch_addr  out  32  pc + (sext(signed_immed_24) << 2)
- status  out  4  registered NZCV, routed to the ID condition check
- stall  out  1  freezes PC, IF/ID and ID/EXE

## Operation
- Operands: op1 = fwd_mux(val_rn), rm_f = fwd_mux(val_rm).
- Val2 when mem_r_en|mem_w_en: zero-extended shift_operand.
- Val2 when imm: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
- Val2 otherwise: rm_f shifted by shift_operand[11:7]. Shift type [6:5]: LSL, LSR, ASR, ROR.
- ALU: ADC adds C. SBC computes op1 - Val2 - !C. MOV and MVN ignore op1.
- Flags: N = res[31], Z = (res == 0). Arithmetic ops produce C (for SUB, C = no borrow) and V (signed overflow). Logic and move ops keep C and V.
- status updates at a clock edge when s=1 and the instruction completes (non-MUL: every cycle with s=1; MUL: the DONE cycle). MUL updates only N and Z.
- MUL FSM:
  - IDLE: on exec_cmd==MUL, capture op1 and rm_f. Forwarded values may change during the stall, so they are not re-read. Clear acc and counter. Go to BUSY.
  - BUSY: each cycle, if the multiplier LSB is set, acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, count++. After count==31, go to DONE.
  - DONE: alu_res = acc (low 32 bits of the product); controls pass through; return to IDLE.
- stall = (IDLE & exec_cmd==MUL) | BUSY.
- While stall=1: wb_en_out, mem_r_en_out and mem_w_en_out are 0 (bubble), and status does not update.

## Timing
- Non-MUL path is fully combinational, inputs to outputs: zero added latency.
- MUL occupies 34 cycles in EXE: 1 IDLE detect + 32 BUSY + 1 DONE. stall is high for the first 33.
- In DONE the ID/EXE register still holds the MUL. The FSM is in IDLE on the next edge, when the following instruction arrives, so the MUL does not retrigger.
- Flushed inputs arrive as all-zero controls (exec_cmd 0000, s=0), so a flush never starts a MUL or writes status.
- branch_taken never coincides with stall: MUL has b=0.
- Reset, any time including mid-MUL: FSM=IDLE, counter=0, acc=0, status=0000. With rst high, stall=0, alu_res=0, branch_taken=0 and all *_out controls are 0.

## Structure
- Shared package arm_pkg: exec_cmd codes including MUL_CMD, shift-type codes, forward-select codes, NZCV bit indices.
- Sub-module val2_gen, combinational, used for the immediate/shift/offset select.
- The ALU, SR, FSM and forwarding muxes live in exe_stage.

## Test plan
- ADD with s=1: rn=0x7FFFFFFF, Val2 imm 1 → alu_res 0x80000000; status 1001 after the edge.
- Immediate rotate: shift_operand=0x4FF (0xFF ror 8), MOV → alu_res 0xFF000000. Register ASR #4 of 0x80000000 → 0xF8000000.
- Forwarding: fwd_sel_rn=01, mem_fwd=5, val_rn=9, SUB imm 2 → alu_res 3. With 10, wb_fwd=20 → 18.
- Branch: pc=0x100, signed_immed_24=0xFFFFFE → branch_taken=1, branch_addr 0xF8.
- MUL: rn=7, rm=6 (captured; mem_fwd changes mid-stall) → stall high for 33 cycles with controls 0, then alu_res 42 with wb_en_out=1. s=1 → Z=0, C/V unchanged.
- rst asserted at BUSY count 10 → stall=0, status 0; a fresh MUL afterwards takes the full 34 cycles.
